// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, hazard/redirect/RET controls and the F2D register outputs.
// master = the fetch stage itself, slave = memory plus the surrounding pipeline.
interface fetch_stage_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 16
);
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic                   stall;
    logic                   flush;
    logic                   redirect_vld;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   pop_vld;
    logic                   pop_hi;
    logic [15:0]            pop_data;
    logic [INSTR_WIDTH-1:0] f2d_instr;
    logic [PC_WIDTH-1:0]    f2d_pc;
    logic                   f2d_valid;
    logic                   f2d_is_imm;
    logic                   fetch_busy;

    modport master (
        output imem_addr, f2d_instr, f2d_pc, f2d_valid, f2d_is_imm, fetch_busy,
        input  imem_data, stall, flush, redirect_vld, redirect_pc, pop_vld, pop_hi, pop_data
    );

    modport slave (
        input  imem_addr, f2d_instr, f2d_pc, f2d_valid, f2d_is_imm, fetch_busy,
        output imem_data, stall, flush, redirect_vld, redirect_pc, pop_vld, pop_hi, pop_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with F2D pipeline register: boots the PC from a two-word reset vector,
// then fetches sequentially, honouring redirects, RET pops, flush and stall.
//
// state  | meaning
// VEC_HI | reading reset-vector high half into pc[31:16]
// VEC_LO | reading reset-vector low half into pc[15:0]
// RUN    | normal fetch; redirect > pop > flush > stall > fetch
module fetch_stage #(
    parameter int                     PC_WIDTH       = 32,
    parameter int                     INSTR_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_VEC_ADDR = '0,
    parameter logic [4:0]             LDM_OPCODE     = 5'h12,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR      = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int HALF = PC_WIDTH / 2;
    localparam logic [PC_WIDTH-1:0] RESET_VEC_LO_ADDR = RESET_VEC_ADDR + PC_WIDTH'(1);

    typedef enum logic [1:0] {
        VEC_HI = 2'd0,
        VEC_LO = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic                   imm_pending_q, imm_pending_d;
    logic [INSTR_WIDTH-1:0] f2d_instr_q, f2d_instr_d;
    logic [PC_WIDTH-1:0]    f2d_pc_q, f2d_pc_d;
    logic                   f2d_valid_q, f2d_valid_d;
    logic                   f2d_is_imm_q, f2d_is_imm_d;
    logic                   bubble;
    logic                   is_ldm;

    assign is_ldm = (bus.imem_data[INSTR_WIDTH-1 -: 5] == LDM_OPCODE);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        imm_pending_d  = imm_pending_q;
        f2d_instr_d    = f2d_instr_q;
        f2d_pc_d       = f2d_pc_q;
        f2d_valid_d    = f2d_valid_q;
        f2d_is_imm_d   = f2d_is_imm_q;
        bubble         = 1'b0;
        bus.imem_addr  = pc_q;
        bus.fetch_busy = 1'b0;

        case (state_q)
            VEC_HI: begin
                bus.imem_addr  = RESET_VEC_ADDR;
                bus.fetch_busy = 1'b1;
                pc_d           = {bus.imem_data, pc_q[HALF-1:0]};
                state_d        = VEC_LO;
                bubble         = 1'b1;
            end
            VEC_LO: begin
                bus.imem_addr  = RESET_VEC_LO_ADDR;
                bus.fetch_busy = 1'b1;
                pc_d           = {pc_q[PC_WIDTH-1:HALF], bus.imem_data};
                state_d        = RUN;
                bubble         = 1'b1;
            end
            RUN: begin
                if (bus.redirect_vld) begin
                    pc_d          = bus.redirect_pc;
                    imm_pending_d = 1'b0;
                    bubble        = 1'b1;
                end else if (bus.pop_vld) begin
                    if (bus.pop_hi) pc_d = {bus.pop_data, pc_q[HALF-1:0]};
                    else            pc_d = {pc_q[PC_WIDTH-1:HALF], bus.pop_data};
                    bubble = 1'b1;
                end else if (bus.flush) begin
                    imm_pending_d = 1'b0;
                    bubble        = 1'b1;
                end else if (!bus.stall) begin
                    f2d_instr_d   = bus.imem_data;
                    f2d_pc_d      = pc_q + PC_WIDTH'(1);
                    f2d_valid_d   = 1'b1;
                    f2d_is_imm_d  = imm_pending_q;
                    pc_d          = pc_q + PC_WIDTH'(1);
                    // an immediate word never arms another immediate, whatever its bits
                    imm_pending_d = !imm_pending_q && is_ldm;
                end
            end
            default: begin
                state_d = VEC_HI;
                bubble  = 1'b1;
            end
        endcase

        if (bubble) begin
            f2d_instr_d  = NOP_INSTR;
            f2d_valid_d  = 1'b0;
            f2d_is_imm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= VEC_HI;
            pc_q          <= '0;
            imm_pending_q <= 1'b0;
            f2d_instr_q   <= NOP_INSTR;
            f2d_pc_q      <= '0;
            f2d_valid_q   <= 1'b0;
            f2d_is_imm_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imm_pending_q <= imm_pending_d;
            f2d_instr_q   <= f2d_instr_d;
            f2d_pc_q      <= f2d_pc_d;
            f2d_valid_q   <= f2d_valid_d;
            f2d_is_imm_q  <= f2d_is_imm_d;
        end
    end

    assign bus.f2d_instr  = f2d_instr_q;
    assign bus.f2d_pc     = f2d_pc_q;
    assign bus.f2d_valid  = f2d_valid_q;
    assign bus.f2d_is_imm = f2d_is_imm_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural fetch model checked every cycle,
// plus hand-computed literal expectations along the scenario.
module tb_fetch_stage;
    logic clk;
    logic rst;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [31:0] ov_addr [8];
    logic [15:0] ov_data [8];

    // memory: a few overridden words, otherwise opcode 3 with the low address bits
    always_comb begin
        bus.imem_data = {5'h03, bus.imem_addr[10:0]};
        for (int i = 0; i < 8; i++)
            if (ov_addr[i] == bus.imem_addr) bus.imem_data = ov_data[i];
    end

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        logic [15:0] w;
        w = {5'h03, a[10:0]};
        for (int i = 0; i < 8; i++)
            if (ov_addr[i] == a) w = ov_data[i];
        return w;
    endfunction

    // model: boot words still to read (2,1,0), pc, pending-immediate flag, expected F2D
    int          m_boot_left;
    logic [31:0] m_pc;
    logic        m_imm;
    logic [15:0] e_instr;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_isimm;

    task automatic make_bubble();
        e_instr = 16'h0000;
        e_valid = 1'b0;
        e_isimm = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        if (rst) begin
            m_boot_left = 2;
            m_pc        = 32'h0;
            m_imm       = 1'b0;
            e_pc        = 32'h0;
            make_bubble();
        end else if (m_boot_left == 2) begin
            m_pc[31:16] = mem_word(32'h0);
            m_boot_left = 1;
            make_bubble();
        end else if (m_boot_left == 1) begin
            m_pc[15:0]  = mem_word(32'h1);
            m_boot_left = 0;
            make_bubble();
        end else if (bus.redirect_vld) begin
            m_pc  = bus.redirect_pc;
            m_imm = 1'b0;
            make_bubble();
        end else if (bus.pop_vld) begin
            if (bus.pop_hi) m_pc[31:16] = bus.pop_data;
            else            m_pc[15:0]  = bus.pop_data;
            make_bubble();
        end else if (bus.flush) begin
            m_imm = 1'b0;
            make_bubble();
        end else if (!bus.stall) begin
            w       = mem_word(m_pc);
            e_instr = w;
            e_pc    = m_pc + 32'd1;
            e_valid = 1'b1;
            e_isimm = m_imm;
            m_imm   = (!m_imm) && (w[15:11] == 5'h12);
            m_pc    = m_pc + 32'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [31:0] exp_addr;
        exp_addr = (m_boot_left == 2) ? 32'h0 : (m_boot_left == 1) ? 32'h1 : m_pc;
        chk("imem_addr",  bus.imem_addr,           exp_addr);
        chk("fetch_busy", {31'h0, bus.fetch_busy}, {31'h0, (m_boot_left != 0)});
        chk("f2d_instr",  {16'h0, bus.f2d_instr},  {16'h0, e_instr});
        chk("f2d_pc",     bus.f2d_pc,              e_pc);
        chk("f2d_valid",  {31'h0, bus.f2d_valid},  {31'h0, e_valid});
        chk("f2d_is_imm", {31'h0, bus.f2d_is_imm}, {31'h0, e_isimm});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic clear_ctl();
        rst              = 1'b0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.redirect_vld = 1'b0;
        bus.redirect_pc  = 32'h0;
        bus.pop_vld      = 1'b0;
        bus.pop_hi       = 1'b0;
        bus.pop_data     = 16'h0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_boot_left = 2;
        m_pc        = 32'h0;
        m_imm       = 1'b0;
        e_pc        = 32'h0;
        make_bubble();
        for (int i = 0; i < 8; i++) begin
            ov_addr[i] = 32'hDEAD_0000 + 32'(i);
            ov_data[i] = 16'h0000;
        end
        ov_addr[0] = 32'h0000_0000;  ov_data[0] = 16'h0000;
        ov_addr[1] = 32'h0000_0001;  ov_data[1] = 16'h0040;
        ov_addr[2] = 32'h0000_0043;  ov_data[2] = 16'h9005;
        ov_addr[3] = 32'h0000_0044;  ov_data[3] = 16'h9000;
        ov_addr[4] = 32'h0000_0047;  ov_data[4] = 16'h9123;
        ov_addr[5] = 32'h0000_0048;  ov_data[5] = 16'h9001;
        ov_addr[6] = 32'h0000_0200;  ov_data[6] = 16'h9777;
        clear_ctl();
        rst = 1'b1;

        // reset and vector boot
        tick();
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_busy",  {31'h0, bus.fetch_busy}, 32'h1);
        chk("rst_valid", {31'h0, bus.f2d_valid}, 32'h0);
        rst = 1'b0;
        tick();
        chk("vec_lo_addr", bus.imem_addr, 32'h1);
        tick();
        chk("run_addr",   bus.imem_addr, 32'h40);
        chk("run_busy",   {31'h0, bus.fetch_busy}, 32'h0);
        chk("boot_valid", {31'h0, bus.f2d_valid}, 32'h0);
        tick();
        chk("first_pc",    bus.f2d_pc, 32'h41);
        chk("first_valid", {31'h0, bus.f2d_valid}, 32'h1);
        chk("first_instr", {16'h0, bus.f2d_instr}, 32'h1840);

        // LDM tagging, immediate with LDM-looking bits
        repeat (3) tick();
        chk("ldm_instr", {16'h0, bus.f2d_instr}, 32'h9005);
        chk("ldm_isimm", {31'h0, bus.f2d_is_imm}, 32'h0);
        tick();
        chk("imm_instr", {16'h0, bus.f2d_instr}, 32'h9000);
        chk("imm_isimm", {31'h0, bus.f2d_is_imm}, 32'h1);
        tick();
        chk("after_imm", {31'h0, bus.f2d_is_imm}, 32'h0);

        // stall while an immediate is pending, then flush under stall
        repeat (2) tick();
        bus.stall = 1'b1;
        repeat (3) tick();
        chk("stall_pc",    bus.f2d_pc, 32'h48);
        chk("stall_addr",  bus.imem_addr, 32'h48);
        chk("stall_instr", {16'h0, bus.f2d_instr}, 32'h9123);
        bus.stall = 1'b0;
        tick();
        chk("stall_imm", {31'h0, bus.f2d_is_imm}, 32'h1);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        chk("flush_valid", {31'h0, bus.f2d_valid}, 32'h0);
        chk("flush_addr",  bus.imem_addr, 32'h49);
        clear_ctl();
        tick();
        chk("refetch_pc",  bus.f2d_pc, 32'h4A);
        chk("refetch_imm", {31'h0, bus.f2d_is_imm}, 32'h0);

        // redirect with stall, then a two-half RET pop
        bus.redirect_vld = 1'b1;
        bus.redirect_pc  = 32'h100;
        bus.stall        = 1'b1;
        tick();
        chk("redir_addr", bus.imem_addr, 32'h100);
        clear_ctl();
        tick();
        chk("redir_pc", bus.f2d_pc, 32'h101);
        bus.pop_vld = 1'b1; bus.pop_hi = 1'b1; bus.pop_data = 16'h0001;
        tick();
        bus.pop_hi = 1'b0; bus.pop_data = 16'h2345;
        tick();
        chk("pop_addr",  bus.imem_addr, 32'h0001_2345);
        chk("pop_valid", {31'h0, bus.f2d_valid}, 32'h0);
        clear_ctl();
        tick();
        chk("ret_pc",    bus.f2d_pc, 32'h0001_2346);
        chk("ret_instr", {16'h0, bus.f2d_instr}, 32'h1B45);

        // redirect beats pop; pc wraps past the top of memory
        bus.redirect_vld = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
        bus.pop_vld = 1'b1; bus.pop_hi = 1'b1; bus.pop_data = 16'hAAAA;
        tick();
        chk("prio_addr", bus.imem_addr, 32'hFFFF_FFFE);
        clear_ctl();
        repeat (2) tick();
        chk("wrap_f2d_pc", bus.f2d_pc, 32'h0);
        chk("wrap_addr",   bus.imem_addr, 32'h0);

        // reset while an immediate is pending; controls ignored during boot
        bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h200;
        tick();
        clear_ctl();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy",  {31'h0, bus.fetch_busy}, 32'h1);
        chk("mid_rst_addr",  bus.imem_addr, 32'h0);
        chk("mid_rst_valid", {31'h0, bus.f2d_valid}, 32'h0);
        rst = 1'b0;
        bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h500;
        bus.stall = 1'b1; bus.pop_vld = 1'b1; bus.pop_hi = 1'b1; bus.pop_data = 16'hBEEF;
        repeat (2) tick();
        chk("reboot_addr", bus.imem_addr, 32'h40);
        clear_ctl();
        tick();
        chk("reboot_imm",   {31'h0, bus.f2d_is_imm}, 32'h0);
        chk("reboot_valid", {31'h0, bus.f2d_valid}, 32'h1);
        chk("reboot_pc",    bus.f2d_pc, 32'h41);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
